// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the SDRAM arbiter, its two requesters and the controller.
// master is the arbiter's view; slave is the view of the surrounding logic.
interface sdram_arbiter_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16
);
   logic                  hi_critical;
   logic                  hi_req;
   logic [ADDR_WIDTH-1:0] hi_addr;
   logic                  hi_ack;
   logic [DATA_WIDTH-1:0] hi_rd_data;
   logic                  lo_req;
   logic                  lo_we;
   logic [ADDR_WIDTH-1:0] lo_addr;
   logic [DATA_WIDTH-1:0] lo_wr_data;
   logic                  lo_ack;
   logic [DATA_WIDTH-1:0] lo_rd_data;
   logic                  lo_idle;
   logic                  sd_enable;
   logic                  sd_we;
   logic [ADDR_WIDTH-1:0] sd_addr;
   logic [DATA_WIDTH-1:0] sd_wr_data;
   logic [DATA_WIDTH-1:0] sd_rd_data;
   logic                  sd_ack;
   logic                  sd_idle;
   logic                  refresh_inhibit;
   logic                  timeout;

   modport master (
      input  hi_critical, hi_req, hi_addr,
      input  lo_req, lo_we, lo_addr, lo_wr_data,
      input  sd_rd_data, sd_ack, sd_idle,
      output hi_ack, hi_rd_data, lo_ack, lo_rd_data, lo_idle,
      output sd_enable, sd_we, sd_addr, sd_wr_data,
      output refresh_inhibit, timeout
   );

   modport slave (
      output hi_critical, hi_req, hi_addr,
      output lo_req, lo_we, lo_addr, lo_wr_data,
      output sd_rd_data, sd_ack, sd_idle,
      input  hi_ack, hi_rd_data, lo_ack, lo_rd_data, lo_idle,
      input  sd_enable, sd_we, sd_addr, sd_wr_data,
      input  refresh_inhibit, timeout
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM access sequencer: high-priority SPI reads, low-priority
// serial read/write, one access at a time with a watchdog abort.
module sdram_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 64,
   parameter int TO_WIDTH   = 7
) (
   input logic            clk,
   input logic            reset,
   sdram_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, HI_BUSY, LO_BUSY} state_t;

   // Abort fires on the edge that would take the count to TIMEOUT, so
   // sd_enable is high for exactly TIMEOUT cycles on a hung access.
   localparam logic [TO_WIDTH-1:0] LAST_COUNT = TO_WIDTH'(TIMEOUT - 1);

   state_t                state, state_next;
   logic                  enable_q, enable_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [TO_WIDTH-1:0]   count_q, count_d;
   logic                  timeout_q, timeout_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         enable_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         enable_q  <= enable_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_next = state;
      enable_d   = enable_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      count_d    = count_q;
      timeout_d  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.hi_req && bus.sd_idle) begin
               state_next = HI_BUSY;
               addr_d     = bus.hi_addr;
               we_d       = 1'b0;
               wdata_d    = DATA_WIDTH'(16'hDEAD);
               enable_d   = 1'b1;
               count_d    = '0;
            end else if (bus.lo_req && !bus.hi_critical && bus.sd_idle) begin
               state_next = LO_BUSY;
               addr_d     = bus.lo_addr;
               we_d       = bus.lo_we;
               wdata_d    = bus.lo_wr_data;
               enable_d   = 1'b1;
               count_d    = '0;
            end
         end
         HI_BUSY, LO_BUSY: begin
            // A completing ack wins over a watchdog expiry in the same cycle.
            if (bus.sd_ack) begin
               state_next = IDLE;
               enable_d   = 1'b0;
               count_d    = '0;
            end else if (count_q == LAST_COUNT) begin
               state_next = IDLE;
               enable_d   = 1'b0;
               count_d    = '0;
               timeout_d  = 1'b1;
            end else begin
               count_d = count_q + TO_WIDTH'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.sd_enable       = enable_q;
   assign bus.sd_we           = we_q;
   assign bus.sd_addr         = addr_q;
   assign bus.sd_wr_data      = wdata_q;
   assign bus.timeout         = timeout_q;
   assign bus.hi_ack          = (state == HI_BUSY) && bus.sd_ack;
   assign bus.lo_ack          = (state == LO_BUSY) && bus.sd_ack;
   assign bus.hi_rd_data      = bus.sd_rd_data;
   assign bus.lo_rd_data      = bus.sd_rd_data;
   assign bus.refresh_inhibit = bus.hi_critical || (state == HI_BUSY);
   assign bus.lo_idle         = (state == IDLE) && !bus.hi_critical && bus.sd_idle;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: table of single accesses plus hand-written
// sequences for priority, blocking, no-preemption, watchdog and reset.
module tb_sdram_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sdram_arbiter_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus ();

   sdram_arbiter #(
      .ADDR_WIDTH(24),
      .DATA_WIDTH(16),
      .TIMEOUT   (64),
      .TO_WIDTH  (7)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic        is_hi;
      logic        we;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          delay;
      logic        exp_we;
      logic [15:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic        is_hi;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every ack pulse must match the oldest outstanding expected completion.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.hi_ack || bus.lo_ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", {30'd0, bus.hi_ack, bus.lo_ack}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_route", {30'd0, bus.hi_ack, bus.lo_ack}, e.is_hi ? 32'd2 : 32'd1);
               check("ack_data", e.is_hi ? bus.hi_rd_data : bus.lo_rd_data, e.data);
            end
         end
      end
   endtask

   task automatic finish_access(input logic [15:0] rdata);
      bus.sd_ack     = 1'b1;
      bus.sd_rd_data = rdata;
      tick();
      bus.sd_ack = 1'b0;
      bus.hi_req = 1'b0;
      bus.lo_req = 1'b0;
      @(negedge clk);
      check("drained", sb.size(), 0);
      check("enable_dropped", bus.sd_enable, 0);
      check("no_timeout", bus.timeout, 0);
   endtask

   task automatic run_vec(input vec_t v);
      tick();
      bus.hi_req     = v.is_hi;
      bus.lo_req     = !v.is_hi;
      bus.hi_addr    = v.addr;
      bus.lo_addr    = v.addr;
      bus.lo_we      = v.we;
      bus.lo_wr_data = v.wdata;
      @(negedge clk);
      check("vec_pre_enable", bus.sd_enable, 0);
      tick();
      @(negedge clk);
      check("vec_enable", bus.sd_enable, 1);
      check("vec_addr", bus.sd_addr, v.addr);
      check("vec_we", bus.sd_we, v.exp_we);
      check("vec_wdata", bus.sd_wr_data, v.exp_wdata);
      check("vec_refresh_inhibit", bus.refresh_inhibit, v.is_hi);
      sb.push_back('{v.is_hi, v.rdata});
      repeat (v.delay) tick();
      finish_access(v.rdata);
   endtask

   initial begin
      int n;
      int bad;

      fork
         begin
            #200000;
            $display("FAIL global_time_limit: got expired expected finish");
            $fatal(1, "time limit");
         end
      join_none

      vecs[0] = '{1'b0, 1'b1, 24'h000123, 16'hBEEF, 16'h0000, 5,  1'b1, 16'hBEEF};
      vecs[1] = '{1'b0, 1'b0, 24'hABCDEF, 16'h7777, 16'h1234, 1,  1'b0, 16'h7777};
      vecs[2] = '{1'b1, 1'b1, 24'h000010, 16'h1111, 16'h00A5, 3,  1'b0, 16'hDEAD};
      vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 16'h2222, 16'hFFFF, 1,  1'b0, 16'hDEAD};
      vecs[4] = '{1'b0, 1'b1, 24'h000000, 16'h0000, 16'h0000, 63, 1'b1, 16'h0000};

      reset          = 1'b1;
      bus.hi_critical = 1'b0;
      bus.hi_req     = 1'b0;
      bus.hi_addr    = '0;
      bus.lo_req     = 1'b0;
      bus.lo_we      = 1'b0;
      bus.lo_addr    = '0;
      bus.lo_wr_data = '0;
      bus.sd_rd_data = '0;
      bus.sd_ack     = 1'b0;
      bus.sd_idle    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_enable", bus.sd_enable, 0);
      check("rst_we", bus.sd_we, 0);
      check("rst_addr", bus.sd_addr, 0);
      check("rst_wdata", bus.sd_wr_data, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_acks", {bus.hi_ack, bus.lo_ack}, 0);
      check("rst_lo_idle", bus.lo_idle, 0);
      check("rst_refresh_inhibit", bus.refresh_inhibit, 0);
      bus.sd_idle = 1'b1;
      #1;
      check("rst_lo_idle_ready", bus.lo_idle, 1);
      tick();
      reset = 1'b0;

      fork
         monitor();
      join_none

      foreach (vecs[i]) run_vec(vecs[i]);

      // Simultaneous requests: hi first, lo on the edge after hi_req drops.
      tick();
      bus.hi_req     = 1'b1;
      bus.hi_addr    = 24'h000010;
      bus.lo_req     = 1'b1;
      bus.lo_we      = 1'b1;
      bus.lo_addr    = 24'h000222;
      bus.lo_wr_data = 16'h5555;
      tick();
      @(negedge clk);
      check("sim_hi_addr", bus.sd_addr, 24'h000010);
      check("sim_hi_we", bus.sd_we, 0);
      sb.push_back('{1'b1, 16'h00A5});
      bad = 0;
      repeat (3) begin
         tick();
         @(negedge clk);
         if (!bus.refresh_inhibit || !bus.sd_enable) bad++;
      end
      check("sim_hi_busy_inhibit", bad, 0);
      tick();
      bus.sd_ack     = 1'b1;
      bus.sd_rd_data = 16'h00A5;
      tick();
      bus.sd_ack = 1'b0;
      bus.hi_req = 1'b0;
      @(negedge clk);
      check("sim_hi_done", sb.size(), 0);
      check("sim_idle_gap", bus.sd_enable, 0);
      check("sim_idle_inhibit", bus.refresh_inhibit, 0);
      tick();
      @(negedge clk);
      check("sim_lo_grant", bus.sd_enable, 1);
      check("sim_lo_addr", bus.sd_addr, 24'h000222);
      check("sim_lo_we", bus.sd_we, 1);
      check("sim_lo_wdata", bus.sd_wr_data, 16'h5555);
      sb.push_back('{1'b0, 16'h0000});
      tick();
      finish_access(16'h0000);

      // hi_critical blocks low grants and lo_idle.
      tick();
      bus.hi_critical = 1'b1;
      bus.lo_req      = 1'b1;
      bus.lo_we       = 1'b1;
      bus.lo_addr     = 24'h000777;
      bus.lo_wr_data  = 16'h4242;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.sd_enable || bus.lo_idle || !bus.refresh_inhibit) bad++;
         tick();
      end
      check("crit_block_violations", bad, 0);
      bus.hi_critical = 1'b0;
      @(negedge clk);
      check("crit_lo_idle", bus.lo_idle, 1);
      check("crit_still_off", bus.sd_enable, 0);
      tick();
      @(negedge clk);
      check("crit_lo_grant", bus.sd_enable, 1);
      check("crit_lo_addr", bus.sd_addr, 24'h000777);
      sb.push_back('{1'b0, 16'h0000});
      tick();
      finish_access(16'h0000);

      // No preemption: hi arrives mid lo access and waits.
      tick();
      bus.lo_req  = 1'b1;
      bus.lo_we   = 1'b0;
      bus.lo_addr = 24'h000333;
      tick();
      tick();
      tick();
      bus.hi_req  = 1'b1;
      bus.hi_addr = 24'h000444;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.sd_addr !== 24'h000333 || !bus.sd_enable) bad++;
         tick();
      end
      check("nopre_addr_held", bad, 0);
      sb.push_back('{1'b0, 16'h0777});
      bus.sd_ack     = 1'b1;
      bus.sd_rd_data = 16'h0777;
      tick();
      bus.sd_ack = 1'b0;
      bus.lo_req = 1'b0;
      @(negedge clk);
      check("nopre_lo_done", sb.size(), 0);
      check("nopre_gap", bus.sd_enable, 0);
      tick();
      @(negedge clk);
      check("nopre_hi_grant", bus.sd_enable, 1);
      check("nopre_hi_addr", bus.sd_addr, 24'h000444);
      check("nopre_hi_we", bus.sd_we, 0);
      sb.push_back('{1'b1, 16'h0444});
      tick();
      finish_access(16'h0444);

      // Watchdog: no ack for a lo access; re-grant while lo_req stays high.
      tick();
      bus.lo_req  = 1'b1;
      bus.lo_we   = 1'b0;
      bus.lo_addr = 24'h000555;
      tick();
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.sd_enable) break;
         n++;
      end
      check("to_enable_cycles", n, 64);
      check("to_pulse", bus.timeout, 1);
      check("to_no_ack", {bus.hi_ack, bus.lo_ack}, 0);
      tick();
      bus.lo_req = 1'b0;
      @(negedge clk);
      check("to_pulse_single", bus.timeout, 0);
      check("to_regrant", bus.sd_enable, 1);
      check("to_regrant_addr", bus.sd_addr, 24'h000555);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.sd_enable) break;
         n++;
      end
      check("to_second_expiry", bus.timeout, 1);
      tick();
      bus.sd_ack     = 1'b1;
      bus.sd_rd_data = 16'h0BAD;
      @(negedge clk);
      check("late_ack_dropped", {bus.hi_ack, bus.lo_ack}, 0);
      check("late_ack_idle", bus.sd_enable, 0);
      tick();
      bus.sd_ack = 1'b0;

      // Reset mid HI_BUSY: abandoned immediately, late ack ignored.
      tick();
      bus.hi_req  = 1'b1;
      bus.hi_addr = 24'h000666;
      tick();
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_enable", bus.sd_enable, 0);
      check("rstmid_addr", bus.sd_addr, 0);
      check("rstmid_state", bus.refresh_inhibit, 0);
      bus.hi_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      bus.sd_ack = 1'b1;
      @(negedge clk);
      check("rstmid_no_ack", {bus.hi_ack, bus.lo_ack}, 0);
      check("rstmid_idle", bus.sd_enable, 0);
      tick();
      bus.sd_ack = 1'b0;
      tick();

      check("sb_empty_end", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
